// File: rtl/imem_loader_if.sv
// Handshake and write-port bundles for the instruction-memory boot loader:
// a byte stream in (valid/ready) and a single-strobe imem write port out.

interface ld_stream_if;
    logic       LD_VALID;
    logic [7:0] LD_DATA;
    logic       LD_READY;

    modport master (output LD_VALID, output LD_DATA, input LD_READY);
    modport slave  (input LD_VALID, input LD_DATA, output LD_READY);
endinterface

interface imem_wr_if #(
    parameter int ADDR_W = 15
);
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_WADDR;
    logic [31:0]       IMEM_WDATA;

    modport master (output IMEM_WE, output IMEM_WADDR, output IMEM_WDATA);
    modport slave  (input IMEM_WE, input IMEM_WADDR, input IMEM_WDATA);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes "N, N little-endian words, checksum byte" off a byte
// stream, writes the words to imem from address 0, then releases the core.

module imem_loader #(
    parameter int IMEM_SIZE = 32768,
    parameter int ADDR_W    = 15
) (
    input  logic        CLK,
    input  logic        RSTN,
    ld_stream_if.slave  ld,
    imem_wr_if.master   imem,
    output logic        CORE_RSTN,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       n_q;
    logic [23:0]       buf_q;
    logic [7:0]        sum_q;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              core_rstn_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic [31:0]       n_d;
    logic [7:0]        sum_d;
    logic              last_word;

    assign accept    = ld.LD_VALID && ready_q;
    // Bytes arrive LSB first, so shifting in from the top leaves them in place.
    assign n_d       = {ld.LD_DATA, n_q[31:8]};
    assign sum_d     = sum_q + ld.LD_DATA;
    assign last_word = (32'(word_q) == (n_q - 32'd1));

    assign ld.LD_READY     = ready_q;
    assign imem.IMEM_WE    = we_q;
    assign imem.IMEM_WADDR = waddr_q;
    assign imem.IMEM_WDATA = wdata_q;
    assign CORE_RSTN       = core_rstn_q;
    assign DONE            = done_q;
    assign ERR             = err_q;

    // NOTE: every register below uses <= so all of them see the pre-edge
    // values of each other; blocking here would make order of statements matter.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_HDR;
            lane_q      <= 2'd0;
            word_q      <= '0;
            n_q         <= 32'd0;
            buf_q       <= 24'd0;
            sum_q       <= 8'd0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        n_q    <= n_d;
                        sum_q  <= sum_d;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            if (n_d > 32'(IMEM_SIZE)) begin
                                state_q <= S_ERR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                            end else if (n_d == 32'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        buf_q  <= {ld.LD_DATA, buf_q[23:8]};
                        sum_q  <= sum_d;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            we_q    <= 1'b1;
                            waddr_q <= word_q;
                            wdata_q <= {ld.LD_DATA, buf_q};
                            word_q  <= word_q + ADDR_W'(1);
                            if (last_word) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (ld.LD_DATA == sum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_rstn_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end

                // Terminal states hold their registered outputs until RSTN.
                S_DONE, S_ERR: begin
                end

                default: begin
                    state_q <= S_ERR;
                    ready_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
